// File: rtl/noc_data_mem_arbiter_if.sv
// Signal bundle between the NIOS data master, the NoC DMA master, the arbiter
// and the single-port data memory.
interface noc_data_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              freeze;
    logic              reset_req;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    // Arbiter side
    modport slave (
        input  freeze, reset_req,
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    // Requester / memory side
    modport master (
        output freeze, reset_req,
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/noc_data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the NIOS data
// master (port 0) and the NoC DMA (port 1), with a bounded burst-hold window.
module noc_data_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    noc_data_mem_arbiter_if.slave   bus
);
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    logic       req0;
    logic       req1;
    logic       blk;
    logic       gnt_valid;
    logic       gnt_port;
    logic       rd_gnt0;
    logic       rd_gnt1;
    logic       last_q;
    logic [3:0] hold_q;
    logic       rv0_q;
    logic       rv1_q;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;
    assign blk  = bus.freeze | bus.reset_req | reset;

    // hold_q == 0 means nobody currently owns a burst, so a tie goes to ~last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (!blk) begin
            if (req0 && req1) begin
                gnt_valid = 1'b1;
                if ((hold_q != 4'd0) && (hold_q < HOLD_LIM))
                    gnt_port = last_q;
                else
                    gnt_port = ~last_q;
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b1;
            end
        end
    end

    // A simultaneous read and write is served as a write, so no read response.
    assign rd_gnt0 = gnt_valid & ~gnt_port & ~bus.m0_write;
    assign rd_gnt1 = gnt_valid &  gnt_port & ~bus.m1_write;

    always_comb begin
        bus.mem_address    = bus.m0_address;
        bus.mem_byteenable = bus.m0_byteenable;
        bus.mem_writedata  = bus.m0_writedata;
        bus.mem_write      = 1'b0;
        if (gnt_valid && gnt_port) begin
            bus.mem_address    = bus.m1_address;
            bus.mem_byteenable = bus.m1_byteenable;
            bus.mem_writedata  = bus.m1_writedata;
            bus.mem_write      = bus.m1_write;
        end else if (gnt_valid) begin
            bus.mem_write      = bus.m0_write;
        end
    end

    assign bus.mem_chipselect   = gnt_valid;
    assign bus.mem_clken        = ~bus.reset_req;
    assign bus.m0_waitrequest   = ~(gnt_valid & ~gnt_port);
    assign bus.m1_waitrequest   = ~(gnt_valid &  gnt_port);
    assign bus.m0_readdata      = bus.mem_readdata;
    assign bus.m1_readdata      = bus.mem_readdata;
    assign bus.m0_readdatavalid = rv0_q;
    assign bus.m1_readdatavalid = rv1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
            hold_q <= 4'd0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
        end else begin
            rv0_q <= rd_gnt0;
            rv1_q <= rd_gnt1;
            if (gnt_valid) begin
                last_q <= gnt_port;
                if (gnt_port == last_q)
                    hold_q <= (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
                else
                    hold_q <= 4'd1;
            end else if (!(last_q ? req1 : req0)) begin
                hold_q <= 4'd0;
            end
        end
    end
endmodule
